mem_requester: RTL and testbench
================================

MEM_REQUESTER -- requirements
Module: mem_requester

Interface
REQ-001 The block SHALL provide these parameters (name, default, meaning):
- MEM_WORDS, 200, data memory depth in 32-bit words.
- PROT_ADDR, 32'h0000_0064, lock-protected byte address.
REQ-002 The block SHALL provide these ports (name, direction, width, meaning), with reset synchronous and active-high on clock clk:
- clk, in, 1, clock; all state updates on posedge.
- reset, in, 1, synchronous active-high reset.
- req_valid, in, 1, core request present.
- req_ready, out, 1, block accepts a request.
- req_write, in, 1, 1 = store, 0 = load.
- req_width, in, 3, width code: 000 SB, 001 SH, 010 W, 100 UB, 101 UH.
- req_addr, in, 32, byte address.
- req_wdata, in, 32, store data.
- resp_valid, out, 1, response present.
- resp_ready, in, 1, core consumes the response.
- resp_rdata, out, 32, load result.
- resp_err, out, 1, request rejected.
- mem_we, out, 1, memory write enable.
- mem_width, out, 3, memory width code.
- mem_addr, out, 32, memory address.
- mem_wdata, out, 32, memory write data.
- mem_rdata, in, 32, memory read data (combinational from mem_addr).
- lock_set, in, 1, sets the protection lock.
- locked, out, 1, lock state.
- err_count, out, 8, saturating count of rejected requests.

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, RESP; req_ready = 1 only in IDLE.
REQ-004 Handshake: on a posedge in IDLE with req_valid = 1, the block SHALL capture write, width, addr and wdata.
REQ-005 After capture, the block SHALL run the error check; pass -> ISSUE, fail -> RESP with resp_err = 1.
REQ-006 Error conditions SHALL be any of the following:
- width code 011, 110 or 111;
- a store with width 100 or 101;
- a halfword width with addr[0] = 1;
- width 010 with addr[1:0] != 0;
- addr[31:2] >= MEM_WORDS;
- a store to PROT_ADDR while locked = 1.
REQ-007 In ISSUE, mem_addr/mem_width/mem_wdata SHALL carry the captured values.
REQ-008 In ISSUE, mem_we SHALL equal the captured write bit for exactly one full clock cycle, so the memory's negedge write lands mid-cycle.
REQ-009 Outside ISSUE, mem_we SHALL be 0, and mem_addr, mem_width and mem_wdata SHALL hold their last values.
REQ-010 At the end of ISSUE, the block SHALL register mem_rdata into resp_rdata for loads; for stores, resp_rdata SHALL be 0. The block SHALL then go to RESP.
REQ-011 In RESP, resp_valid SHALL be 1 and stay stable until resp_ready = 1. On that posedge the block SHALL return to IDLE.
REQ-012 There SHALL be no back-to-back acceptance: after a response is consumed, the block SHALL spend at least one cycle in IDLE before the next request.
REQ-013 Latency SHALL be as follows (accept at posedge N):
- success: ISSUE during cycle N..N+1, resp_valid at N+2;
- error: resp_valid at N+1, and mem_we is never asserted.
REQ-014 For an error response, resp_rdata SHALL be 0.
REQ-015 locked SHALL be a defined register: 0 after reset, set by lock_set = 1, and sticky until reset.
REQ-016 A lock_set in the same cycle as a request capture SHALL apply to that request's check.
REQ-017 Loads of PROT_ADDR SHALL always be allowed.
REQ-018 err_count SHALL increment by 1 per error response and saturate at 8'hFF.

Reset
REQ-019 While reset = 1 at a posedge, the following SHALL be set:
- state = IDLE;
- req_ready = 1;
- resp_valid = 0, resp_err = 0, resp_rdata = 0;
- mem_we = 0, mem_addr = 0, mem_width = 0, mem_wdata = 0;
- locked = 0, err_count = 0.
REQ-020 Reset in ISSUE or RESP SHALL drop the transaction with no response. mem_we SHALL be 0 from the cycle after reset is sampled.
REQ-021 Reset SHALL take priority over lock_set and over req_valid.

Verification
REQ-022 Word store then load: store 0xDEADBEEF to 0x10 (width 010), then load 0x10 -> resp_rdata = 0xDEADBEEF, resp_err = 0, resp_valid 2 cycles after accept.
REQ-023 Byte/half loads: memory word 0x10 = 0x8000_80F0; SB at 0x10 -> 0xFFFFFFF0; UB at 0x10 -> 0x000000F0; UH at 0x12 -> 0x00008000.
REQ-024 Misalignment: W store at 0x11 -> resp_err = 1 one cycle after accept, mem_we never 1, memory unchanged, err_count = 1.
REQ-025 Lock: pulse lock_set, then W store 0x12345678 to 0x64 -> resp_err = 1 and the word is unchanged. Reset, then repeat the store without lock_set -> success and the word = 0x12345678.
REQ-026 Backpressure/bounds: hold resp_ready = 0 for 5 cycles -> resp_valid and resp_rdata stay stable and req_ready = 0. A load at 0x320 -> resp_err = 1.
REQ-027 Reset mid-op: assert reset during ISSUE of a store -> resp_valid is never 1, state = IDLE, locked = 0, err_count = 0. After 256 errors, err_count = 0xFF.

Source files
------------

// File: rtl/mem_requester.sv
// Core-to-memory request sequencer: accepts one load/store, validates it,
// drives a single memory cycle and returns a response with error reporting.
module mem_requester #(
    parameter int unsigned MEM_WORDS = 200,
    parameter logic [31:0] PROT_ADDR = 32'h0000_0064
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_width,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [2:0]  mem_width,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        lock_set,
    output logic        locked,
    output logic [7:0]  err_count
);

    localparam int unsigned AW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   accept_c;
    logic   req_err_c;
    logic   bad_code_c;
    logic   bad_store_c;
    logic   half_mis_c;
    logic   word_mis_c;
    logic   out_of_range_c;
    logic   prot_hit_c;
    logic   cap_write;

    // Request validation; a lock_set arriving with the request already counts.
    always_comb begin
        bad_code_c     = (req_width == 3'b011) || (req_width == 3'b110) ||
                         (req_width == 3'b111);
        bad_store_c    = req_write && ((req_width == 3'b100) || (req_width == 3'b101));
        half_mis_c     = (req_width[1:0] == 2'b01) && req_addr[0];
        word_mis_c     = (req_width == 3'b010) && (req_addr[1:0] != 2'b00);
        out_of_range_c = AW'({2'b00, req_addr[31:2]}) >= AW'(MEM_WORDS);
        prot_hit_c     = req_write && (req_addr == PROT_ADDR) && (locked || lock_set);
        req_err_c      = bad_code_c || bad_store_c || half_mis_c || word_mis_c ||
                         out_of_range_c || prot_hit_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: errors skip the memory cycle and go straight to RESP.
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    accept_c   = 1'b1;
                    state_next = req_err_c ? RESP : ISSUE;
                end
            end
            ISSUE: state_next = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs; memory address/data only change on a valid accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            mem_we     <= 1'b0;
            mem_width  <= 3'd0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            locked     <= 1'b0;
            err_count  <= 8'd0;
            cap_write  <= 1'b0;
        end else begin
            req_ready  <= (state_next == IDLE);
            resp_valid <= (state_next == RESP);
            mem_we     <= 1'b0;
            if (lock_set) begin
                locked <= 1'b1;
            end
            if (accept_c && !req_err_c) begin
                cap_write <= req_write;
                mem_we    <= req_write;
                mem_width <= req_width;
                mem_addr  <= req_addr;
                mem_wdata <= req_wdata;
            end
            if (accept_c && req_err_c) begin
                resp_err   <= 1'b1;
                resp_rdata <= 32'd0;
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
            if (state == ISSUE) begin
                resp_err   <= 1'b0;
                resp_rdata <= cap_write ? 32'd0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_requester.sv
// Directed bench for mem_requester with a byte-addressed memory model that
// reads combinationally and writes on the falling edge.
module tb_mem_requester;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_width;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [2:0]  mem_width;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        lock_set;
    logic        locked;
    logic [7:0]  err_count;

    int checks = 0;
    int passes = 0;
    int we_cycles = 0;
    int rv_cycles = 0;

    logic [31:0] mem [0:255];
    logic [31:0] mw;
    logic [31:0] msh;

    mem_requester #(.MEM_WORDS(200), .PROT_ADDR(32'h0000_0064)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_width(req_width), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_we(mem_we), .mem_width(mem_width), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .lock_set(lock_set), .locked(locked), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        mw  = mem[mem_addr[9:2]];
        msh = mw >> {mem_addr[1:0], 3'b000};
        case (mem_width)
            3'b000:  mem_rdata = {{24{msh[7]}}, msh[7:0]};
            3'b001:  mem_rdata = {{16{msh[15]}}, msh[15:0]};
            3'b100:  mem_rdata = {24'd0, msh[7:0]};
            3'b101:  mem_rdata = {16'd0, msh[15:0]};
            default: mem_rdata = mw;
        endcase
    end

    always @(negedge clk) begin
        if (mem_we) begin
            case (mem_width)
                3'b000:  mem[mem_addr[9:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
                3'b001:  mem[mem_addr[9:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
                default: mem[mem_addr[9:2]] <= mem_wdata;
            endcase
        end
    end

    always @(posedge clk) begin
        if (mem_we) we_cycles <= we_cycles + 1;
        if (resp_valid) rv_cycles <= rv_cycles + 1;
    end

    // One transaction: returns data, error flag, accept-to-valid edges and write cycles.
    task automatic do_req(input logic wr, input logic [2:0] w, input logic [31:0] a,
                          input logic [31:0] d, input logic ls,
                          output logic [31:0] rd, output logic er,
                          output int lat, output int we_n);
        bit acc;
        bit got;
        int start_we;
        rd = 32'd0; er = 1'b0; lat = -1; we_n = -1;
        req_valid = 1'b1; req_write = wr; req_width = w; req_addr = a;
        req_wdata = d; lock_set = ls;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin
            acc = req_ready;
            @(posedge clk); #1;
        end
        req_valid = 1'b0; lock_set = 1'b0;
        if (!acc) begin
            checks++;
            $display("FAIL accept_timeout addr=%h", a);
            return;
        end
        start_we = we_cycles;
        got = 1'b0;
        for (int i = 1; i <= 10 && !got; i++) begin
            if (resp_valid) begin
                got = 1'b1; lat = i;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!got) begin
            checks++;
            $display("FAIL resp_timeout addr=%h", a);
            return;
        end
        rd = resp_rdata; er = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        we_n = we_cycles - start_we;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b1; lock_set = 1'b1;
        req_write = 1'b1; req_width = 3'b010; req_addr = 32'h40; req_wdata = 32'h1;
        repeat (2) @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got=%b exp=1", req_ready); else passes++;
        checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); else passes++;
        checks++; if (resp_err !== 1'b0) $display("FAIL rst_resp_err got=%b exp=0", resp_err); else passes++;
        checks++; if (resp_rdata !== 32'd0) $display("FAIL rst_resp_rdata got=%h exp=0", resp_rdata); else passes++;
        checks++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we got=%b exp=0", mem_we); else passes++;
        checks++; if ({mem_addr, mem_width, mem_wdata} !== 67'd0)
            $display("FAIL rst_mem_bus got=%h/%h/%h exp=0", mem_addr, mem_width, mem_wdata); else passes++;
        checks++; if (locked !== 1'b0) $display("FAIL rst_locked got=%b exp=0", locked); else passes++;
        checks++; if (err_count !== 8'd0) $display("FAIL rst_err_count got=%h exp=0", err_count); else passes++;
        req_valid = 1'b0; lock_set = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat; int wn;
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, rd, er, lat, wn);
        checks++; if (er !== 1'b0 || lat != 2) $display("FAIL w_store err=%b lat=%0d exp err=0 lat=2", er, lat); else passes++;
        checks++; if (wn != 1) $display("FAIL w_store_we_cycles got=%0d exp=1", wn); else passes++;
        checks++; if (rd !== 32'd0) $display("FAIL w_store_rdata got=%h exp=0", rd); else passes++;
        checks++; if (mem[4] !== 32'hDEADBEEF) $display("FAIL w_store_mem got=%h exp=deadbeef", mem[4]); else passes++;
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, er, lat, wn);
        checks++; if (rd !== 32'hDEADBEEF) $display("FAIL w_load got=%h exp=deadbeef", rd); else passes++;
        checks++; if (er !== 1'b0 || lat != 2 || wn != 0)
            $display("FAIL w_load_timing err=%b lat=%0d we=%0d exp 0/2/0", er, lat, wn); else passes++;
    endtask

    task automatic test_subword();
        logic [31:0] rd; logic er; int lat; int wn;
        do_req(1'b1, 3'b010, 32'h10, 32'h800080F0, 1'b0, rd, er, lat, wn);
        do_req(1'b0, 3'b000, 32'h10, 32'h0, 1'b0, rd, er, lat, wn);
        checks++; if (rd !== 32'hFFFFFFF0 || er !== 1'b0) $display("FAIL sb_load got=%h err=%b exp=fffffff0", rd, er); else passes++;
        do_req(1'b0, 3'b100, 32'h10, 32'h0, 1'b0, rd, er, lat, wn);
        checks++; if (rd !== 32'h000000F0 || er !== 1'b0) $display("FAIL ub_load got=%h err=%b exp=000000f0", rd, er); else passes++;
        do_req(1'b0, 3'b101, 32'h12, 32'h0, 1'b0, rd, er, lat, wn);
        checks++; if (rd !== 32'h00008000 || er !== 1'b0) $display("FAIL uh_load got=%h err=%b exp=00008000", rd, er); else passes++;
        do_req(1'b0, 3'b001, 32'h12, 32'h0, 1'b0, rd, er, lat, wn);
        checks++; if (rd !== 32'hFFFF8000 || er !== 1'b0) $display("FAIL sh_load got=%h err=%b exp=ffff8000", rd, er); else passes++;
        do_req(1'b1, 3'b000, 32'h13, 32'h000000AA, 1'b0, rd, er, lat, wn);
        checks++; if (mem[4] !== 32'hAA0080F0 || er !== 1'b0) $display("FAIL sb_store got=%h err=%b exp=aa0080f0", mem[4], er); else passes++;
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat; int wn;
        apply_reset();
        do_req(1'b0, 3'b101, 32'h12, 32'h0, 1'b0, rd, er, lat, wn);
        do_req(1'b1, 3'b010, 32'h11, 32'h11111111, 1'b0, rd, er, lat, wn);
        checks++; if (er !== 1'b1 || lat != 1) $display("FAIL misalign err=%b lat=%0d exp err=1 lat=1", er, lat); else passes++;
        checks++; if (wn != 0 || rd !== 32'd0) $display("FAIL misalign_we_rdata we=%0d rd=%h exp 0/0", wn, rd); else passes++;
        checks++; if (mem[4] !== 32'hAA0080F0) $display("FAIL misalign_mem got=%h exp=aa0080f0", mem[4]); else passes++;
        checks++; if (err_count !== 8'd1) $display("FAIL misalign_count got=%0d exp=1", err_count); else passes++;
        checks++; if (mem_addr !== 32'h12 || mem_width !== 3'b101)
            $display("FAIL mem_bus_hold got=%h/%b exp=12/101", mem_addr, mem_width); else passes++;
        do_req(1'b0, 3'b011, 32'h10, 32'h0, 1'b0, rd, er, lat, wn);
        checks++; if (er !== 1'b1) $display("FAIL bad_code err=%b exp=1", er); else passes++;
        do_req(1'b1, 3'b100, 32'h10, 32'h0, 1'b0, rd, er, lat, wn);
        checks++; if (er !== 1'b1 || mem[4] !== 32'hAA0080F0) $display("FAIL ub_store err=%b mem=%h exp=1/aa0080f0", er, mem[4]); else passes++;
        do_req(1'b0, 3'b001, 32'h13, 32'h0, 1'b0, rd, er, lat, wn);
        checks++; if (er !== 1'b1) $display("FAIL half_misalign err=%b exp=1", er); else passes++;
        checks++; if (err_count !== 8'd4) $display("FAIL err_count4 got=%0d exp=4", err_count); else passes++;
    endtask

    task automatic test_lock();
        logic [31:0] rd; logic er; int lat; int wn;
        do_req(1'b1, 3'b010, 32'h64, 32'h0BADF00D, 1'b0, rd, er, lat, wn);
        lock_set = 1'b1; @(posedge clk); #1; lock_set = 1'b0;
        checks++; if (locked !== 1'b1) $display("FAIL lock_set got=%b exp=1", locked); else passes++;
        do_req(1'b1, 3'b010, 32'h64, 32'h12345678, 1'b0, rd, er, lat, wn);
        checks++; if (er !== 1'b1 || wn != 0 || mem[25] !== 32'h0BADF00D)
            $display("FAIL lock_store err=%b we=%0d mem=%h exp 1/0/0badf00d", er, wn, mem[25]); else passes++;
        do_req(1'b0, 3'b010, 32'h64, 32'h0, 1'b0, rd, er, lat, wn);
        checks++; if (er !== 1'b0 || rd !== 32'h0BADF00D) $display("FAIL lock_load err=%b rd=%h exp 0/0badf00d", er, rd); else passes++;
        apply_reset();
        do_req(1'b1, 3'b010, 32'h64, 32'h12345678, 1'b0, rd, er, lat, wn);
        checks++; if (er !== 1'b0 || mem[25] !== 32'h12345678)
            $display("FAIL unlock_store err=%b mem=%h exp 0/12345678", er, mem[25]); else passes++;
        do_req(1'b1, 3'b010, 32'h64, 32'hCAFEF00D, 1'b1, rd, er, lat, wn);
        checks++; if (er !== 1'b1 || mem[25] !== 32'h12345678)
            $display("FAIL same_cycle_lock err=%b mem=%h exp 1/12345678", er, mem[25]); else passes++;
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; int wn;
        bit acc; bit got;
        req_valid = 1'b1; req_write = 1'b0; req_width = 3'b010; req_addr = 32'h10;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin acc = req_ready; @(posedge clk); #1; end
        req_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (resp_valid) got = 1'b1; else begin @(posedge clk); #1; end
        end
        checks++; if (!acc || !got) $display("FAIL bp_handshake acc=%b got=%b exp 1/1", acc, got); else passes++;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== 32'hAA0080F0)
                $display("FAIL bp_hold cyc=%0d valid=%b ready=%b rd=%h exp 1/0/aa0080f0", i, resp_valid, req_ready, resp_rdata);
            else passes++;
        end
        resp_ready = 1'b1; @(posedge clk); #1; resp_ready = 1'b0;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL bp_release valid=%b ready=%b exp 0/1", resp_valid, req_ready); else passes++;
        do_req(1'b0, 3'b010, 32'h320, 32'h0, 1'b0, rd, er, lat, wn);
        checks++; if (er !== 1'b1 || lat != 1) $display("FAIL out_of_range err=%b lat=%0d exp 1/1", er, lat); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat; int wn;
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, rd, er, lat, wn);
        checks++; if (rd !== 32'h000000AA) $display("FAIL b2b_first got=%h exp=000000aa", rd); else passes++;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0)
            $display("FAIL b2b_idle ready=%b valid=%b exp 1/0", req_ready, resp_valid); else passes++;
        do_req(1'b0, 3'b100, 32'h10, 32'h0, 1'b0, rd, er, lat, wn);
        checks++; if (rd !== 32'h000000F0 || lat != 2) $display("FAIL b2b_second got=%h lat=%0d exp f0/2", rd, lat); else passes++;
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] rd; logic er; int lat; int wn;
        bit acc; int rv_start;
        lock_set = 1'b1; @(posedge clk); #1; lock_set = 1'b0;
        do_req(1'b0, 3'b111, 32'h0, 32'h0, 1'b0, rd, er, lat, wn);
        req_valid = 1'b1; req_write = 1'b1; req_width = 3'b010; req_addr = 32'h20; req_wdata = 32'h55;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin acc = req_ready; @(posedge clk); #1; end
        req_valid = 1'b0;
        checks++; if (!acc || mem_we !== 1'b1) $display("FAIL mid_issue acc=%b we=%b exp 1/1", acc, mem_we); else passes++;
        rv_start = rv_cycles;
        reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
        checks++; if (mem_we !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL mid_reset we=%b ready=%b exp 0/1", mem_we, req_ready); else passes++;
        checks++; if (locked !== 1'b0 || err_count !== 8'd0)
            $display("FAIL mid_reset_regs locked=%b cnt=%0d exp 0/0", locked, err_count); else passes++;
        repeat (5) @(posedge clk); #1;
        checks++; if (rv_cycles != rv_start || req_ready !== 1'b1)
            $display("FAIL mid_reset_noresp rv=%0d ready=%b exp 0/1", rv_cycles - rv_start, req_ready); else passes++;
    endtask

    task automatic test_saturation();
        logic [31:0] rd; logic er; int lat; int wn;
        apply_reset();
        for (int i = 0; i < 254; i++) do_req(1'b0, 3'b010, 32'h1, 32'h0, 1'b0, rd, er, lat, wn);
        checks++; if (err_count !== 8'hFE) $display("FAIL count_254 got=%h exp=fe", err_count); else passes++;
        do_req(1'b0, 3'b010, 32'h1, 32'h0, 1'b0, rd, er, lat, wn);
        checks++; if (err_count !== 8'hFF) $display("FAIL count_255 got=%h exp=ff", err_count); else passes++;
        do_req(1'b0, 3'b010, 32'h1, 32'h0, 1'b0, rd, er, lat, wn);
        checks++; if (err_count !== 8'hFF || er !== 1'b1) $display("FAIL count_sat got=%h err=%b exp ff/1", err_count, er); else passes++;
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_width = 3'b000;
        req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0; lock_set = 1'b0;
        test_reset();
        test_word();
        test_subword();
        test_errors();
        test_lock();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        test_saturation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
